// File: rtl/arbitro_rr.sv
// arbitro_rr: round-robin burst scheduler between 4 FWFT input FIFOs and
// 4 output FIFOs. The two MSBs of each word select the destination FIFO.
// A granted source keeps the path for up to MAX_BURST words, then ownership
// rotates. Output FIFOs hold off traffic through their almostfull flags.
// Optional macro ARB_XFER_COUNT_EN adds 8-bit per-source pop counters
// (xfer_cnt_p0..xfer_cnt_p3).
module arbitro_rr #(
    parameter int FIFO_WORD_SIZE = 10,
    parameter int MAX_BURST      = 4,
    parameter int CNT_WIDTH      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      empty_p0,
    input  logic                      empty_p1,
    input  logic                      empty_p2,
    input  logic                      empty_p3,
    input  logic                      almostfull_p0,
    input  logic                      almostfull_p1,
    input  logic                      almostfull_p2,
    input  logic                      almostfull_p3,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_0,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_1,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_2,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_3,
    output logic                      pop_p0,
    output logic                      pop_p1,
    output logic                      pop_p2,
    output logic                      pop_p3,
    output logic [FIFO_WORD_SIZE-1:0] data_out,
    output logic                      push_p0,
    output logic                      push_p1,
    output logic                      push_p2,
    output logic                      push_p3,
    output logic [1:0]                grant,
    output logic                      busy
`ifdef ARB_XFER_COUNT_EN
    ,
    output logic [7:0]                xfer_cnt_p0,
    output logic [7:0]                xfer_cnt_p1,
    output logic [7:0]                xfer_cnt_p2,
    output logic [7:0]                xfer_cnt_p3
`endif
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_BURST);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam bit                   MULTI_WORD = (MAX_BURST > 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Registered state
    state_t                    state_reg;
    logic [1:0]                rr_ptr_reg;
    logic [CNT_WIDTH-1:0]      burst_cnt_reg;
    logic [1:0]                grant_reg;
    logic                      busy_reg;
    logic [FIFO_WORD_SIZE-1:0] data_out_reg;
    logic [3:0]                push_reg;

    // Per-source views of the scalar ports
    logic [3:0]                empty_v;
    logic [3:0]                af_v;
    logic [FIFO_WORD_SIZE-1:0] din [4];
    logic [1:0]                dest [4];
    logic [3:0]                elig;

    // Arbitration results
    logic                      win_found;
    logic [1:0]                win_idx;
    logic [3:0]                pop_v;
    logic                      take;
    logic [1:0]                sel;
    logic [FIFO_WORD_SIZE-1:0] sel_word;
    logic [3:0]                push_next;

    assign empty_v = {empty_p3, empty_p2, empty_p1, empty_p0};
    assign af_v    = {almostfull_p3, almostfull_p2, almostfull_p1, almostfull_p0};
    assign din[0]  = data_in_0;
    assign din[1]  = data_in_1;
    assign din[2]  = data_in_2;
    assign din[3]  = data_in_3;

    // A source is eligible when it has a word and that word's destination
    // is not almost full; checked every cycle, word by word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_elig
            assign dest[gi] = din[gi][FIFO_WORD_SIZE-1:FIFO_WORD_SIZE-2];
            assign elig[gi] = !empty_v[gi] && !af_v[dest[gi]];
        end
    endgenerate

    // Round-robin search starting just after the last owner
    always_comb begin
        logic [1:0] idx;
        win_found = 1'b0;
        win_idx   = 2'd0;
        idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_ptr_reg + 2'(k);
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Pop decode: new grant in IDLE, continuation of the owner in BURST.
    // Reset suppresses every pop immediately.
    always_comb begin
        pop_v = 4'b0000;
        if (!reset) begin
            case (state_reg)
                IDLE: begin
                    if (enable && win_found) begin
                        pop_v[win_idx] = 1'b1;
                    end
                end
                BURST: begin
                    if (enable && elig[grant_reg] && (burst_cnt_reg < MAX_CNT)) begin
                        pop_v[grant_reg] = 1'b1;
                    end
                end
                default: pop_v = 4'b0000;
            endcase
        end
    end

    // Word selection and one-hot destination decode for the popped word
    always_comb begin
        take      = |pop_v;
        sel       = (state_reg == IDLE) ? win_idx : grant_reg;
        sel_word  = din[sel];
        push_next = 4'b0000;
        if (take) begin
            push_next[dest[sel]] = 1'b1;
        end
    end

    assign pop_p0 = pop_v[0];
    assign pop_p1 = pop_v[1];
    assign pop_p2 = pop_v[2];
    assign pop_p3 = pop_v[3];

    // Scheduler FSM with registered outputs; the word popped this cycle
    // reaches data_out/push on the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 2'd3;
            burst_cnt_reg <= '0;
            grant_reg     <= 2'd0;
            busy_reg      <= 1'b0;
            data_out_reg  <= '0;
            push_reg      <= 4'b0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (take) begin
                        grant_reg     <= win_idx;
                        data_out_reg  <= sel_word;
                        push_reg      <= push_next;
                        burst_cnt_reg <= CNT_ONE;
                        if (MULTI_WORD) begin
                            busy_reg  <= 1'b1;
                            state_reg <= BURST;
                        end else begin
                            rr_ptr_reg <= win_idx;
                        end
                    end else begin
                        push_reg <= 4'b0000;
                    end
                end
                BURST: begin
                    if (take) begin
                        data_out_reg  <= sel_word;
                        push_reg      <= push_next;
                        burst_cnt_reg <= burst_cnt_reg + CNT_ONE;
                    end else begin
                        // Release: one bubble cycle, ownership rotates past grant
                        state_reg     <= IDLE;
                        rr_ptr_reg    <= grant_reg;
                        burst_cnt_reg <= '0;
                        busy_reg      <= 1'b0;
                        push_reg      <= 4'b0000;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    push_reg  <= 4'b0000;
                end
            endcase
        end
    end

    assign data_out = data_out_reg;
    assign push_p0  = push_reg[0];
    assign push_p1  = push_reg[1];
    assign push_p2  = push_reg[2];
    assign push_p3  = push_reg[3];
    assign grant    = grant_reg;
    assign busy     = busy_reg;

`ifdef ARB_XFER_COUNT_EN
    logic [7:0] xfer_cnt_reg [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_xfer
            // Free-running 8-bit pop counter per source, wraps naturally
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    xfer_cnt_reg[gi] <= 8'd0;
                end else if (pop_v[gi]) begin
                    xfer_cnt_reg[gi] <= xfer_cnt_reg[gi] + 8'd1;
                end
            end
        end
    endgenerate

    assign xfer_cnt_p0 = xfer_cnt_reg[0];
    assign xfer_cnt_p1 = xfer_cnt_reg[1];
    assign xfer_cnt_p2 = xfer_cnt_reg[2];
    assign xfer_cnt_p3 = xfer_cnt_reg[3];
`endif

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed self-checking bench for arbitro_rr. Input FIFOs are modelled as
// FWFT queues whose heads drive data_in/empty; expected values are hand
// computed for each step.
module tb_arbitro_rr;

    localparam int W = 10;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [3:0]   empty_v;
    logic [3:0]   af_v;
    logic [W-1:0] din [4];
    logic         pop_p0, pop_p1, pop_p2, pop_p3;
    logic         push_p0, push_p1, push_p2, push_p3;
    logic [W-1:0] data_out;
    logic [1:0]   grant;
    logic         busy;
    logic [3:0]   pop;
    logic [3:0]   push;
`ifdef ARB_XFER_COUNT_EN
    logic [7:0]   xc0, xc1, xc2, xc3;
`endif

    logic [W-1:0] fq [4][$];
    int total = 0;
    int bad   = 0;

    assign pop  = {pop_p3, pop_p2, pop_p1, pop_p0};
    assign push = {push_p3, push_p2, push_p1, push_p0};

    arbitro_rr #(.FIFO_WORD_SIZE(W), .MAX_BURST(4), .CNT_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .empty_p0(empty_v[0]), .empty_p1(empty_v[1]),
        .empty_p2(empty_v[2]), .empty_p3(empty_v[3]),
        .almostfull_p0(af_v[0]), .almostfull_p1(af_v[1]),
        .almostfull_p2(af_v[2]), .almostfull_p3(af_v[3]),
        .data_in_0(din[0]), .data_in_1(din[1]),
        .data_in_2(din[2]), .data_in_3(din[3]),
        .pop_p0(pop_p0), .pop_p1(pop_p1), .pop_p2(pop_p2), .pop_p3(pop_p3),
        .data_out(data_out),
        .push_p0(push_p0), .push_p1(push_p1), .push_p2(push_p2), .push_p3(push_p3),
        .grant(grant), .busy(busy)
`ifdef ARB_XFER_COUNT_EN
        , .xfer_cnt_p0(xc0), .xfer_cnt_p1(xc1), .xfer_cnt_p2(xc2), .xfer_cnt_p3(xc3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-12s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present queue heads as FWFT FIFO outputs
    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            empty_v[i] = (fq[i].size() == 0);
            din[i]     = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    // One clock: pops seen before the edge remove queue heads after it
    task automatic step();
        logic [3:0] p;
        p = pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (p[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        end
        settle();
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        af_v   = 4'b0000;
        for (int i = 0; i < 4; i++) fq[i].push_back(W'(i + 1));
        drive();

        // Reset held with all inputs non-empty
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pop", 32'(pop), 32'h0);
        chk("rst_push", 32'(push), 32'h0);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
`ifdef ARB_XFER_COUNT_EN
        chk("rst_xc0", 32'(xc0), 32'h0);
        chk("rst_xc3", 32'(xc3), 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;

        // One word in each input: grants rotate 0,1,2,3 with a bubble between
        for (int i = 0; i < 4; i++) begin
            chk("rr_pop", 32'(pop), 32'(1 << i));
            step();
            chk("rr_grant", 32'(grant), 32'(i));
            chk("rr_busy", 32'(busy), 32'h1);
            chk("rr_push", 32'(push), 32'h1);
            chk("rr_data", 32'(data_out), 32'(i + 1));
            chk("rr_nopop", 32'(pop), 32'h0);
            step();
            chk("rr_rel_busy", 32'(busy), 32'h0);
            chk("rr_rel_push", 32'(push), 32'h0);
        end
        chk("rr_idle_pop", 32'(pop), 32'h0);
        fq[0].push_back(10'h005);
        settle();
        chk("rr_wrap_pop", 32'(pop), 32'h1);
        step();
        chk("rr_wrap_grant", 32'(grant), 32'h0);
        chk("rr_wrap_data", 32'(data_out), 32'h005);
        step();

        // Six words on p2 to dest 1: burst of 4, bubble, burst of 2
        for (int k = 1; k <= 6; k++) fq[2].push_back(10'h100 + W'(k));
        settle();
        for (int k = 1; k <= 4; k++) begin
            chk("b_pop", 32'(pop), 32'h4);
            step();
            chk("b_data", 32'(data_out), 32'h100 + 32'(k));
            chk("b_push", 32'(push), 32'h2);
            chk("b_grant", 32'(grant), 32'h2);
        end
        chk("b_cap_pop", 32'(pop), 32'h0);
        step();
        chk("b_bub_busy", 32'(busy), 32'h0);
        chk("b_bub_push", 32'(push), 32'h0);
        chk("b_bub_data", 32'(data_out), 32'h104);
        for (int k = 5; k <= 6; k++) begin
            chk("b2_pop", 32'(pop), 32'h4);
            step();
            chk("b2_data", 32'(data_out), 32'h100 + 32'(k));
            chk("b2_busy", 32'(busy), 32'h1);
        end
        chk("b2_end_pop", 32'(pop), 32'h0);
        step();
        chk("b2_rel_busy", 32'(busy), 32'h0);

        // Blocked destination: p0 -> dest 3 (almost full), p1 -> dest 0
        af_v[3] = 1'b1;
        fq[0].push_back(10'h301);
        fq[1].push_back(10'h002);
        settle();
        chk("af_pop", 32'(pop), 32'h2);
        step();
        chk("af_grant", 32'(grant), 32'h1);
        chk("af_data", 32'(data_out), 32'h002);
        chk("af_push", 32'(push), 32'h1);
        chk("af_nopop", 32'(pop), 32'h0);
        step();
        chk("af_blk_pop", 32'(pop), 32'h0);
        af_v[3] = 1'b0;
        settle();
        chk("af_clr_pop", 32'(pop), 32'h1);
        step();
        chk("af_clr_grant", 32'(grant), 32'h0);
        chk("af_clr_push", 32'(push), 32'h8);
        chk("af_clr_data", 32'(data_out), 32'h301);
        step();

        // almostfull rises on the second word of a p0 burst to dest 2
        fq[0].push_back(10'h201);
        fq[0].push_back(10'h202);
        fq[0].push_back(10'h203);
        settle();
        chk("af2_pop", 32'(pop), 32'h1);
        step();
        chk("af2_data", 32'(data_out), 32'h201);
        af_v[2] = 1'b1;
        fq[1].push_back(10'h004);
        settle();
        chk("af2_block", 32'(pop), 32'h0);
        chk("af2_inflt", 32'(push), 32'h4);
        step();
        chk("af2_busy", 32'(busy), 32'h0);
        chk("af2_push0", 32'(push), 32'h0);
        chk("af2_next", 32'(pop), 32'h2);
        step();
        chk("af2_grant", 32'(grant), 32'h1);
        chk("af2_data1", 32'(data_out), 32'h004);
        af_v[2] = 1'b0;
        settle();
        step();
        chk("af2_p0_pop", 32'(pop), 32'h1);
        step();
        chk("af2_p0_data", 32'(data_out), 32'h202);

        // enable drops mid-burst: release then resume with no lost word
        enable = 1'b0;
        settle();
        chk("en_pop", 32'(pop), 32'h0);
        step();
        chk("en_busy", 32'(busy), 32'h0);
        chk("en_push", 32'(push), 32'h0);
        chk("en_hold", 32'(data_out), 32'h202);
        chk("en_idle_pop", 32'(pop), 32'h0);
        enable = 1'b1;
        settle();
        chk("en_res_pop", 32'(pop), 32'h1);
        step();
        chk("en_res_data", 32'(data_out), 32'h203);
        chk("en_res_grant", 32'(grant), 32'h0);
        step();

`ifdef ARB_XFER_COUNT_EN
        // 255 more pops on p3 (one earlier) makes 256: counter wraps to 0
        begin
            int n;
            n = 0;
            for (int k = 0; k < 255; k++) fq[3].push_back(W'(k & 8'hff));
            settle();
            while ((fq[3].size() != 0 || busy) && n < 3000) begin
                step();
                n++;
            end
            chk("xc_timeout", 32'(n < 3000), 32'h1);
            chk("xc3_wrap", 32'(xc3), 32'h0);
            chk("xc0", 32'(xc0), 32'h6);
            chk("xc1", 32'(xc1), 32'h3);
            chk("xc2", 32'(xc2), 32'h7);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
